// File: rtl/video_timing_gen_if.sv
// Raster timing bundle produced by video_timing_gen and consumed by the arcade video path.
interface video_timing_gen_if;
  logic       ce_pix;
  logic       HBlank;
  logic       VBlank;
  logic       HSync;
  logic       VSync;
  logic [9:0] hcount;
  logic [8:0] vcount;
  logic       frame_start;

  modport master (
    output ce_pix, HBlank, VBlank, HSync, VSync, hcount, vcount, frame_start
  );

  modport slave (
    input ce_pix, HBlank, VBlank, HSync, VSync, hcount, vcount, frame_start
  );
endinterface

// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel enable, blanking, sync and pixel coordinates.
// Optional macro VTG_POS_ADJ_EN adds per-frame signed sync position adjust (h_adj/v_adj).
module video_timing_gen #(
  parameter int unsigned CE_DIV   = 4,
  parameter int unsigned H_ACTIVE = 320,
  parameter int unsigned H_FP     = 8,
  parameter int unsigned H_SYNC   = 32,
  parameter int unsigned H_BP     = 40,
  parameter int unsigned V_ACTIVE = 240,
  parameter int unsigned V_FP     = 4,
  parameter int unsigned V_SYNC   = 3,
  parameter int unsigned V_BP     = 15,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0
) (
  input  logic clk_video,
  input  logic reset_n,
`ifdef VTG_POS_ADJ_EN
  input  logic [3:0] h_adj,
  input  logic [3:0] v_adj,
`endif
  video_timing_gen_if.master vid
);

  localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DivW   = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;

  localparam logic [DivW-1:0] DivLast = DivW'(CE_DIV - 1);
  localparam logic [9:0]      HLast   = 10'(HTotal - 1);
  localparam logic [8:0]      VLast   = 9'(VTotal - 1);

  localparam int HsNom   = int'(H_ACTIVE + H_FP);
  localparam int HsMin   = int'(H_ACTIVE);
  localparam int HsMax   = int'(HTotal - H_SYNC);
  localparam int HSyncW  = int'(H_SYNC);
  localparam int VsNom   = int'(V_ACTIVE + V_FP);
  localparam int VsMin   = int'(V_ACTIVE);
  localparam int VsMax   = int'(VTotal - V_SYNC);
  localparam int VSyncW  = int'(V_SYNC);

  logic [DivW-1:0] div_q, div_d;
  logic            tick;
  logic [9:0]      hcount_q, hcount_d;
  logic [8:0]      vcount_q, vcount_d;
  logic            ce_q;
  logic            hblank_q, hblank_d;
  logic            vblank_q, vblank_d;
  logic            hsync_q, hsync_d;
  logic            vsync_q, vsync_d;
  logic            frame_start_q, frame_start_d;
  int              hs_start, vs_start;

`ifdef VTG_POS_ADJ_EN
  logic [3:0] h_adj_q, v_adj_q;

  function automatic int clamp(int val, int lo, int hi);
    if (val < lo) return lo;
    if (val > hi) return hi;
    return val;
  endfunction

  // Latch adjusts only on the frame_start edge so one frame never mixes two sync positions.
  always_ff @(posedge clk_video or negedge reset_n) begin
    if (!reset_n) begin
      h_adj_q <= '0;
      v_adj_q <= '0;
    end else if (frame_start_d) begin
      h_adj_q <= h_adj;
      v_adj_q <= v_adj;
    end
  end

  assign hs_start = clamp(HsNom + int'($signed(h_adj_q)), HsMin, HsMax);
  assign vs_start = clamp(VsNom + int'($signed(v_adj_q)), VsMin, VsMax);
`else
  assign hs_start = HsNom;
  assign vs_start = VsNom;
`endif

  // Pixel divider and raster counter next-state.
  always_comb begin
    tick     = (div_q == DivLast);
    div_d    = tick ? '0 : div_q + 1'b1;
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    if (tick) begin
      if (hcount_q == HLast) begin
        hcount_d = '0;
        vcount_d = (vcount_q == VLast) ? '0 : vcount_q + 1'b1;
      end else begin
        hcount_d = hcount_q + 1'b1;
      end
    end
  end

  // Decode from next-state counters so flags change together with hcount/vcount;
  // vcount_d only moves on the hcount wrap, which aligns VBlank/VSync with HBlank falling.
  always_comb begin
    hblank_d      = (hcount_d >= 10'(H_ACTIVE));
    vblank_d      = (vcount_d >= 9'(V_ACTIVE));
    hsync_d       = (int'(hcount_d) >= hs_start && int'(hcount_d) < hs_start + HSyncW)
                    ? HS_POL : ~HS_POL;
    vsync_d       = (int'(vcount_d) >= vs_start && int'(vcount_d) < vs_start + VSyncW)
                    ? VS_POL : ~VS_POL;
    frame_start_d = tick && (hcount_d == '0) && (vcount_d == '0);
  end

  // State and registered outputs; ce_pix rises on the same edge the counters advance.
  always_ff @(posedge clk_video or negedge reset_n) begin
    if (!reset_n) begin
      div_q         <= '0;
      hcount_q      <= '0;
      vcount_q      <= '0;
      ce_q          <= 1'b0;
      hblank_q      <= 1'b0;
      vblank_q      <= 1'b0;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      ce_q          <= tick;
      hblank_q      <= hblank_d;
      vblank_q      <= vblank_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vid.ce_pix      = ce_q;
  assign vid.HBlank      = hblank_q;
  assign vid.VBlank      = vblank_q;
  assign vid.HSync       = hsync_q;
  assign vid.VSync       = vsync_q;
  assign vid.hcount      = hcount_q;
  assign vid.vcount      = vcount_q;
  assign vid.frame_start = frame_start_q;

endmodule
